// File: rtl/cipher_store_pkg.sv
// Shared ciphertext store defaults, used by the store and by the push-button,
// display and transmit blocks that size their buses from it.
package cipher_store_pkg;

    localparam int unsigned DEFAULT_DATAWIDTH = 12;
    localparam int unsigned DEFAULT_DATADEPTH = 16;
    localparam int unsigned MAX_READERS       = 8;

endpackage

// File: rtl/cipher_store_arbiter_rr_arbiter.sv
// N-way round-robin arbiter. Grant is combinational from the request vector;
// the rotating pointer advances past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    int            w_j;

    // Scan from the pointer downwards in priority so the closest request wins.
    always_comb begin
        w_idx   = r_ptr;
        w_j     = 0;
        o_grant = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= int'(N)) begin
                w_j = w_j - int'(N);
            end
            if (i_req[w_j]) begin
                w_idx = PW'(w_j);
            end
        end
        if (i_en && |i_req) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en && |i_req) begin
            r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cipher_store_arbiter.sv
// Ciphertext store: auto-addressed write port plus NUM_READERS round-robin read
// ports sharing one single-port, synchronously read RAM. Writes win over reads.
module cipher_store_arbiter
    import cipher_store_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = DEFAULT_DATAWIDTH,
    parameter int unsigned DATADEPTH   = DEFAULT_DATADEPTH,
    parameter int unsigned NUM_READERS = 2,
    localparam int unsigned AW         = $clog2(DATADEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clear,
    input  logic                      i_wr_req,
    input  logic [DATAWIDTH-1:0]      i_wr_data,
    output logic                      o_wr_ack,
    output logic [AW-1:0]             o_wr_addr,
    output logic [AW:0]               o_count,
    output logic                      o_full,
    output logic                      o_overflow,
    input  logic [NUM_READERS-1:0]    i_rd_req,
    input  logic [NUM_READERS*AW-1:0] i_rd_addr,
    output logic [NUM_READERS-1:0]    o_rd_valid,
    output logic [DATAWIDTH-1:0]      o_rd_data
);

    logic [DATAWIDTH-1:0]   r_mem [DATADEPTH];
    logic [AW-1:0]          r_wr_addr;
    logic [AW:0]            r_count;
    logic                   r_overflow;
    logic                   r_wr_ack;
    logic [NUM_READERS-1:0] r_rd_valid;
    logic [DATAWIDTH-1:0]   r_rd_data;

    logic                   w_full;
    logic                   w_wr_accept;
    logic                   w_rd_en;
    logic [NUM_READERS-1:0] w_grant;
    logic [AW-1:0]          w_rd_addr;
    logic                   w_rd_in_range;

    assign w_full      = (r_count == (AW + 1)'(DATADEPTH));
    assign w_wr_accept = !i_rst && !i_clear && i_wr_req && !w_full;
    // A write while full does not use the RAM, so reads may still proceed.
    assign w_rd_en     = !i_rst && !i_clear && !(i_wr_req && !w_full);

    rr_arbiter #(
        .N (NUM_READERS)
    ) u_rr_arbiter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_rd_en),
        .i_req   (i_rd_req),
        .o_grant (w_grant)
    );

    always_comb begin
        w_rd_addr = '0;
        for (int i = 0; i < int'(NUM_READERS); i++) begin
            if (w_grant[i]) begin
                w_rd_addr = w_rd_addr | i_rd_addr[i*AW +: AW];
            end
        end
    end

    assign w_rd_in_range = ({1'b0, w_rd_addr} < (AW + 1)'(DATADEPTH));

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_addr  <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_wr_ack   <= w_wr_accept;
            r_rd_valid <= w_grant;
            if (|w_grant) begin
                r_rd_data <= w_rd_in_range ? r_mem[w_rd_addr] : '0;
            end
            if (i_clear) begin
                r_wr_addr  <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (i_wr_req) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_addr <= (r_wr_addr == AW'(DATADEPTH - 1)) ? '0 : r_wr_addr + 1'b1;
                    r_count   <= r_count + 1'b1;
                end
            end
        end
    end

    assign o_wr_ack   = r_wr_ack;
    assign o_wr_addr  = r_wr_addr;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_cipher_store_arbiter.sv
// Directed bench for cipher_store_arbiter with three readers and a 16-word store.
module tb_cipher_store_arbiter;

    localparam int unsigned DW = 12;
    localparam int unsigned DD = 16;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic           wr_req;
    logic [DW-1:0]  wr_data;
    logic           wr_ack;
    logic [AW-1:0]  wr_addr;
    logic [AW:0]    count;
    logic           full;
    logic           overflow;
    logic [NR-1:0]  rd_req;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]  rd_valid;
    logic [DW-1:0]  rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cipher_store_arbiter #(
        .DATAWIDTH   (DW),
        .DATADEPTH   (DD),
        .NUM_READERS (NR)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (clear),
        .i_wr_req   (wr_req),
        .i_wr_data  (wr_data),
        .o_wr_ack   (wr_ack),
        .o_wr_addr  (wr_addr),
        .o_count    (count),
        .o_full     (full),
        .o_overflow (overflow),
        .i_rd_req   (rd_req),
        .i_rd_addr  (rd_addr),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data)
    );

    // Inputs change 1 ns after a rising edge; outputs are observed at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; wr_req = 1'b0; rd_req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; wr_req = 1'b1; wr_data = 12'hABC;
        rd_req = '1; rd_addr = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({wr_ack, wr_addr, count, full, overflow, rd_valid, rd_data} !== '0) begin
                errors++;
                $display("FAIL reset_during cyc%0d: ack=%b addr=%0d cnt=%0d full=%b ovf=%b vld=%b data=%h, need all 0",
                         c, wr_ack, wr_addr, count, full, overflow, rd_valid, rd_data);
            end
        end
        rst = 1'b0; wr_req = 1'b0; rd_req = '0;
        step();
        checks++;
        if ({wr_ack, wr_addr, count, full, overflow, rd_valid} !== '0) begin
            errors++;
            $display("FAIL reset_after: ack=%b addr=%0d cnt=%0d full=%b ovf=%b vld=%b, need all 0",
                     wr_ack, wr_addr, count, full, overflow, rd_valid);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] words [3];
        words[0] = 12'hA5C; words[1] = 12'h123; words[2] = 12'hFFF;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; wr_data = words[i];
            step();
            checks++;
            if (wr_ack !== 1'b1) begin
                errors++;
                $display("FAIL wr_ack%0d: got %b need 1", i, wr_ack);
            end
        end
        wr_req = 1'b0;
        checks++;
        if (count !== 5'd3 || wr_addr !== 4'd3) begin
            errors++;
            $display("FAIL wr_count: count=%0d addr=%0d need 3/3", count, wr_addr);
        end
        rd_req = 3'b010; rd_addr[1*AW +: AW] = 4'd1;
        step();
        rd_req = '0;
        checks++;
        if (rd_valid !== 3'b010 || rd_data !== 12'h123) begin
            errors++;
            $display("FAIL rd1_addr1: vld=%b data=%h need 010/123", rd_valid, rd_data);
        end
        step();
        checks++;
        if (wr_ack !== 1'b0 || rd_valid !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_read: ack=%b vld=%b need 0/000", wr_ack, rd_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_v [3];
        logic [DW-1:0] exp_d [3];
        exp_v[0] = 3'b001; exp_v[1] = 3'b010; exp_v[2] = 3'b100;
        exp_d[0] = 12'h100; exp_d[1] = 12'h201; exp_d[2] = 12'h302;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; wr_data = exp_d[i];
            step();
        end
        wr_req = 1'b0;
        rd_req = 3'b111;
        rd_addr[0 +: AW] = 4'd0; rd_addr[AW +: AW] = 4'd1; rd_addr[2*AW +: AW] = 4'd2;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (rd_valid !== exp_v[c % 3] || rd_data !== exp_d[c % 3]) begin
                errors++;
                $display("FAIL rr_cyc%0d: vld=%b data=%h need %b/%h",
                         c, rd_valid, rd_data, exp_v[c % 3], exp_d[c % 3]);
            end
        end
        rd_req = '0;
        step();
        checks++;
        if (rd_valid !== 3'b000) begin
            errors++;
            $display("FAIL rr_stop: vld=%b need 000", rd_valid);
        end
    endtask

    task automatic test_collision();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; wr_data = 12'h0A0 + DW'(i);
            step();
        end
        wr_req = 1'b1; wr_data = 12'h0B2;
        rd_req = 3'b001; rd_addr[0 +: AW] = 4'd4;
        step();
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b1 || rd_valid !== 3'b000) begin
            errors++;
            $display("FAIL coll_write_first: ack=%b vld=%b need 1/000", wr_ack, rd_valid);
        end
        step();
        rd_req = '0;
        checks++;
        if (wr_ack !== 1'b0 || rd_valid !== 3'b001 || rd_data !== 12'h0B2) begin
            errors++;
            $display("FAIL coll_read_after: ack=%b vld=%b data=%h need 0/001/0b2",
                     wr_ack, rd_valid, rd_data);
        end
        step();
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_req = 1'b1; wr_data = 12'h800 + DW'(i);
            step();
            checks++;
            if (wr_ack !== 1'b1) begin
                errors++;
                $display("FAIL fill_ack%0d: got %b need 1", i, wr_ack);
            end
        end
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || wr_addr !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_state: full=%b cnt=%0d addr=%0d ovf=%b need 1/16/0/0",
                     full, count, wr_addr, overflow);
        end
        wr_data = 12'h777;
        step();
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b0 || overflow !== 1'b1 || count !== 5'd16 || wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL overflow: ack=%b ovf=%b cnt=%0d addr=%0d need 0/1/16/0",
                     wr_ack, overflow, count, wr_addr);
        end
        rd_req = 3'b001; rd_addr[0 +: AW] = 4'd0;
        step();
        rd_req = '0;
        checks++;
        if (rd_valid !== 3'b001 || rd_data !== 12'h800) begin
            errors++;
            $display("FAIL ram0_kept: vld=%b data=%h need 001/800", rd_valid, rd_data);
        end
        step();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b need 1", overflow);
        end
    endtask

    // Runs straight after the overflow test so clear has a set overflow to drop.
    task automatic test_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (count !== 5'd0 || wr_addr !== 4'd0 || overflow !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL clear_from_full: cnt=%0d addr=%0d ovf=%b full=%b need 0/0/0/0",
                     count, wr_addr, overflow, full);
        end
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_data = 12'hC00 + DW'(i);
            step();
        end
        checks++;
        if (count !== 5'd5 || wr_addr !== 4'd5) begin
            errors++;
            $display("FAIL five_writes: cnt=%0d addr=%0d need 5/5", count, wr_addr);
        end
        clear = 1'b1; wr_req = 1'b1; wr_data = 12'hEEE;
        step();
        clear = 1'b0; wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b0 || count !== 5'd0 || wr_addr !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_with_write: ack=%b cnt=%0d addr=%0d ovf=%b need 0/0/0/0",
                     wr_ack, count, wr_addr, overflow);
        end
        rd_req = 3'b001; rd_addr[0 +: AW] = 4'd2;
        step();
        checks++;
        if (rd_valid !== 3'b001 || rd_data !== 12'hC02) begin
            errors++;
            $display("FAIL clear_retains: vld=%b data=%h need 001/c02", rd_valid, rd_data);
        end
        rd_addr[0 +: AW] = 4'd5;
        step();
        rd_req = '0;
        checks++;
        if (rd_valid !== 3'b001 || rd_data !== 12'h805) begin
            errors++;
            $display("FAIL dropped_write: vld=%b data=%h need 001/805", rd_valid, rd_data);
        end
        wr_req = 1'b1; wr_data = 12'hD00;
        step();
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b1 || count !== 5'd1 || wr_addr !== 4'd1) begin
            errors++;
            $display("FAIL write_after_clear: ack=%b cnt=%0d addr=%0d need 1/1/1",
                     wr_ack, count, wr_addr);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; wr_req = 1'b0; wr_data = '0; rd_req = '0; rd_addr = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_collision();
        test_full_overflow();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cipher_store_arbiter.md
# cipher_store_arbiter

Parametrised ciphertext store with one auto-addressed write port and NUM_READERS arbitrated read ports. It replaces the fixed write / two-read RAM control pair between the encryption engine, the display path and the UART transmit path. Writes take priority, and readers are served round-robin with a registered one-cycle latency. Fill count, full and overflow status are provided so producers need no separate address counter.

## Interface
- DATAWIDTH, 12, ciphertext word width
- DATADEPTH, 16, number of stored words (need not be a power of two)
- NUM_READERS, 2, number of read ports (1..8)
- AW (localparam), $clog2(DATADEPTH), address width

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  single-cycle pulse; empties the store logically
- wr_req  in  1  write request; wr_data is stored at the next write address
- wr_data  in  DATAWIDTH  word to store
- wr_ack  out  1  one-cycle pulse: write committed
- wr_addr  out  AW  address the next accepted write will use
- count  out  AW+1  number of valid words, 0..DATADEPTH
- full  out  1  count == DATADEPTH
- overflow  out  1  sticky; a write was attempted while full
- rd_req  in  NUM_READERS  per-reader read request, level
- rd_addr  in  NUM_READERS*AW  flattened per-reader address; reader i uses bits [i*AW +: AW]
- rd_valid  out  NUM_READERS  one-hot pulse: rd_data belongs to reader i
- rd_data  out  DATAWIDTH  shared read data bus, qualified by rd_valid

## Operation
- Reset: wr_ack=0, wr_addr=0, count=0, full=0, overflow=0, rd_valid=0, rd_data=0.
  - Round-robin pointer is set to reader 0.
  - RAM contents are not reset.
- Port arbitration is decided each cycle from the sampled inputs. Priority order:
  - clear
  - wr_req && !full
  - round-robin among the asserted rd_req bits
- One RAM operation is performed per cycle, on a single-port, synchronously read RAM.
- Accepted write:
  - RAM[wr_addr] <= wr_data.
  - wr_addr increments, wrapping from DATADEPTH-1 to 0.
  - count increments.
- Write while full: ignored. No ack, RAM and wr_addr unchanged, overflow <= 1.
- Read service:
  - The reader winning the round-robin has RAM[rd_addr[i]] read.
  - After service the pointer moves to i+1 mod NUM_READERS.
  - Pointer is unchanged when no read is served.
- Reader protocol:
  - The requester holds rd_req and rd_addr until its rd_valid is seen.
  - rd_req still high in the rd_valid cycle counts as a new request.
- rd_addr >= DATADEPTH returns zero data, and rd_valid still pulses.
- clear:
  - Sets wr_addr=0, count=0, overflow=0.
  - A simultaneous write is dropped without an ack.
  - RAM contents are retained and stay readable.
  - A read already issued completes normally.
- Reads are not checked against count; stale data is returned as stored.

## Timing
- Inputs are sampled at a rising edge E.
- wr_ack and updated wr_addr/count/full/overflow are visible in the cycle after E.
- A read granted at E has rd_valid[i] and rd_data present in the cycle after E, for exactly one cycle.
- Throughput: one operation per cycle.
- Latency for an uncontended read: 1 cycle.
- A read contending with a write or other readers waits; worst case is 1 + (NUM_READERS-1) cycles plus any cycles taken by writes.
- Read-after-write: a read of address A issued in the cycle after A's write returns the new data. No bypass is needed because writes and reads are serialised.
- rd_data holds its last value when rd_valid=0; this is don't-care for consumers.
- rst overrides all other inputs in the same cycle. A pending rd_valid is suppressed.

## Structure
- Package cipher_store_pkg: default DATAWIDTH/DATADEPTH constants and a MAX_READERS=8 constant. These are shared with the push-button, display and transmit blocks.
- Sub-module rr_arbiter:
  - Parametrised N-way round-robin arbiter.
  - Inputs: req vector, enable, rst.
  - Outputs: one-hot grant.
  - Owns the rotating pointer.
- The RAM is inferred inside the block, with no vendor IP dependency.

## Test plan
- Reset: assert rst with wr_req/rd_req high -> all outputs 0 during and after reset, count=0, full=0.
- Write then read: write 0xA5C, 0x123, 0xFFF -> three wr_ack pulses, count=3, wr_addr=3. Reader 1 reads address 1 -> rd_valid=2'b10 next cycle with rd_data=0x123.
- Round-robin, NUM_READERS=3: hold all rd_req high with addresses 0/1/2 -> rd_valid sequence 001, 010, 100, 001… with matching data.
- Full/overflow, DATADEPTH=16: 16 writes -> full=1, count=16, wr_addr=0. 17th write (0x777) -> no ack, overflow=1, RAM[0] unchanged.
- Write/read collision: wr_req and rd_req[0] (address 4) in the same cycle, where 0x0B2 is the word that write stores at address 4 -> wr_ack next cycle, rd_valid[0] one cycle later with 0x0B2.
- Clear: clear together with wr_req after 5 writes -> no ack, count=0, wr_addr=0, overflow=0. A read of address 2 still returns the third word written.
